// File: rtl/cpu6502_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6502_pkg
//  Purpose  : Shared definitions for the 6502 program-counter stages:
//             interrupt/reset vector page, PC fixup state encoding and the
//             floating-bus value used by the tri-state drivers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cpu6502_pkg;

    // High byte of every hardware vector (FFFA/FFFC/FFFE)
    localparam logic [7:0] VECTOR_PAGE = 8'hFF;

    // Value driven by a released bus driver
    localparam logic [7:0] BUS_FLOAT = 8'hzz;

    // Branch page-cross fixup state
    typedef enum logic [0:0] {
        PCF_IDLE = 1'b0,
        PCF_FIX  = 1'b1
    } pcf_state_e;

endpackage : cpu6502_pkg
`default_nettype wire

// File: rtl/pc_high_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_high_if
//  Purpose  : Control/status bundle between the sequencer (master) and the
//             PC high-byte stage (slave).
//  Signals  : adhin/adhwa       ADH bus load value and strobe
//             inc/pclc          PC increment and low-byte carry
//             setreset/nmi/irq  vector page loads
//             brreq/brneg       branch page-cross fixup request/direction
//             adhoa/dboa        output enables for the ADH / data buses
//             pchc              PC wrap indication
//             fixbusy           fixup cycle in progress (sequencer stalls)
//             savedpch/restore  PCH save/restore (PC_HIGH_SAVE_EN only)
//  Revision : 1.0  initial release
// ============================================================================
interface pc_high_if;
    logic [7:0] adhin;
    logic       adhwa;
    logic       inc;
    logic       pclc;
    logic       setreset;
    logic       setnmi;
    logic       setirq;
    logic       brreq;
    logic       brneg;
    logic       adhoa;
    logic       dboa;
    logic       pchc;
    logic       fixbusy;
`ifdef PC_HIGH_SAVE_EN
    logic [7:0] savedpch;
    logic       restore;
`endif

    modport master (
        output adhin, adhwa, inc, pclc, setreset, setnmi, setirq,
               brreq, brneg, adhoa, dboa,
`ifdef PC_HIGH_SAVE_EN
        output restore,
        input  savedpch,
`endif
        input  pchc, fixbusy
    );

    modport slave (
        input  adhin, adhwa, inc, pclc, setreset, setnmi, setirq,
               brreq, brneg, adhoa, dboa,
`ifdef PC_HIGH_SAVE_EN
        input  restore,
        output savedpch,
`endif
        output pchc, fixbusy
    );
endinterface : pc_high_if
`default_nettype wire

// File: rtl/pc_tribuf.sv
`default_nettype none
// ============================================================================
//  Module   : pc_tribuf
//  Purpose  : 8-bit tri-state bus driver, shared by the PC low/high stages.
//  Ports    : en  drive enable
//             d   value to drive
//             q   d when en, otherwise floating
//  Revision : 1.0  initial release
// ============================================================================
module pc_tribuf
    import cpu6502_pkg::*;
(
    input  wire       en,
    input  wire [7:0] d,
    output wire [7:0] q
);

    assign q = en ? d : BUS_FLOAT;

endmodule : pc_tribuf
`default_nettype wire

// File: rtl/pc_high.sv
`default_nettype none
// ============================================================================
//  Module   : pc_high
//  Purpose  : 6502 program-counter high byte. Increments on the low-byte
//             carry, loads from the ADH bus or the vector page, applies the
//             one-cycle branch page-cross fixup and drives PCH onto the ADH
//             and data buses.
//  Ports    : clk     core clock
//             rstn    synchronous active-low reset
//             bus     pc_high_if.slave control/status bundle
//             adhout  PCH when adhoa, else floating
//             dbout   PCH when dboa,  else floating
//  Options  : PC_HIGH_SAVE_EN adds savedpch/restore (PCH save on NMI/IRQ).
//  Revision : 1.0  initial release
// ============================================================================
module pc_high #(
    parameter logic [7:0] VECTOR_PAGE = cpu6502_pkg::VECTOR_PAGE,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  wire        clk,
    input  wire        rstn,
    pc_high_if.slave   bus,
    // Tri-state outputs stay direct ports so they can join shared bus nets
    output wire [7:0]  adhout,
    output wire [7:0]  dbout
);
    import cpu6502_pkg::*;

    logic [7:0] pch_q;
    pcf_state_e state_q;
    logic       dirq_q;
    logic       w_inc_carry;

    assign w_inc_carry = bus.inc & bus.pclc;
    assign bus.pchc    = w_inc_carry & (pch_q == 8'hFF);
    assign bus.fixbusy = (state_q == PCF_FIX);

`ifdef PC_HIGH_SAVE_EN
    logic [7:0] savedpch_q;
    assign bus.savedpch = savedpch_q;
`endif

    // Single priority chain; any load also cancels a pending fixup
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pch_q   <= RESET_VAL;
            state_q <= PCF_IDLE;
            dirq_q  <= 1'b0;
`ifdef PC_HIGH_SAVE_EN
            savedpch_q <= 8'h00;
`endif
        end else if (bus.setreset) begin
            pch_q   <= VECTOR_PAGE;
            state_q <= PCF_IDLE;
        end else if (bus.setnmi || bus.setirq) begin
`ifdef PC_HIGH_SAVE_EN
            savedpch_q <= pch_q;   // pre-load value, for the return path
`endif
            pch_q   <= VECTOR_PAGE;
            state_q <= PCF_IDLE;
`ifdef PC_HIGH_SAVE_EN
        end else if (bus.restore) begin
            pch_q   <= savedpch_q;
            state_q <= PCF_IDLE;
`endif
        end else if (bus.adhwa) begin
            pch_q   <= bus.adhin;
            state_q <= PCF_IDLE;
        end else if (state_q == PCF_FIX) begin
            // Sequencer is stalled here: inc/pclc and brreq are ignored
            pch_q   <= dirq_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
            state_q <= PCF_IDLE;
        end else begin
            if (bus.brreq) begin
                state_q <= PCF_FIX;
                dirq_q  <= bus.brneg;
            end
            // Carry from the low byte still lands on the request edge
            if (w_inc_carry) begin
                pch_q <= pch_q + 8'd1;
            end
        end
    end

    pc_tribuf u_adh_buf (
        .en (bus.adhoa),
        .d  (pch_q),
        .q  (adhout)
    );

    pc_tribuf u_db_buf (
        .en (bus.dboa),
        .d  (pch_q),
        .q  (dbout)
    );

endmodule : pc_high
`default_nettype wire

// File: tb/tb_pc_high.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_high
//  Purpose  : Directed self-checking bench for pc_high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_high;

    logic       clk;
    logic       rstn;
    wire  [7:0] adhout;
    wire  [7:0] dbout;
    int         checks;
    int         errors;

    pc_high_if bus ();

    pc_high dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus.slave),
        .adhout (adhout),
        .dbout  (dbout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load PCH through the ADH bus in one cycle
    task automatic load(input logic [7:0] v);
        bus.adhwa = 1'b1;
        bus.adhin = v;
        tick();
        bus.adhwa = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.adhin = 8'h00; bus.adhwa = 1'b0; bus.inc = 1'b0; bus.pclc = 1'b0;
        bus.setreset = 1'b0; bus.setnmi = 1'b0; bus.setirq = 1'b0;
        bus.brreq = 1'b0; bus.brneg = 1'b0; bus.adhoa = 1'b1; bus.dboa = 1'b1;
`ifdef PC_HIGH_SAVE_EN
        bus.restore = 1'b0;
`endif

        // 1. Reset, load, drive
        tick();
        chk("rst_adhout", adhout, 8'h00);
        chk("rst_dbout", dbout, 8'h00);
        chk("rst_fixbusy", {7'd0, bus.fixbusy}, 8'h00);
        chk("rst_pchc", {7'd0, bus.pchc}, 8'h00);
        rstn = 1'b1;
        bus.dboa = 1'b0;
        load(8'h12);
        chk("load_adhout", adhout, 8'h12);
        checks++;
        assert (dbout === 8'hzz) else begin
            errors++;
            $error("FAIL dbout_float observed %h expected zz", dbout);
        end

        // 2. Carry increment and wrap
        load(8'h34);
        bus.inc = 1'b1; bus.pclc = 1'b1;
        #1 chk("pchc_no_wrap", {7'd0, bus.pchc}, 8'h00);
        tick();
        chk("inc_carry", adhout, 8'h35);
        bus.pclc = 1'b0;
        tick();
        chk("inc_nocarry", adhout, 8'h35);
        bus.inc = 1'b0;
        load(8'hFF);
        bus.inc = 1'b1; bus.pclc = 1'b1;
        #1 chk("pchc_wrap", {7'd0, bus.pchc}, 8'h01);
        tick();
        chk("wrap_pch", adhout, 8'h00);
        bus.inc = 1'b0;
        tick();
        chk("pclc_only", adhout, 8'h00);
        bus.pclc = 1'b0;

        // 3. Vector priority
        bus.setreset = 1'b1; bus.setirq = 1'b1; bus.adhwa = 1'b1; bus.adhin = 8'h55;
        tick();
        chk("vec_reset_prio", adhout, 8'hFF);
        bus.setreset = 1'b0; bus.setirq = 1'b0; bus.adhwa = 1'b0;
        load(8'h10);
        bus.setnmi = 1'b1; bus.setirq = 1'b1;
        tick();
        chk("vec_nmi_irq", adhout, 8'hFF);
        bus.setnmi = 1'b0; bus.setirq = 1'b0;
`ifdef PC_HIGH_SAVE_EN
        load(8'hC0);
        bus.setirq = 1'b1;
        tick();
        bus.setirq = 1'b0;
        chk("save_vec", adhout, 8'hFF);
        chk("savedpch", bus.savedpch, 8'hC0);
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        chk("restore", adhout, 8'hC0);
`endif

        // 4. Fixup, +1 with brreq held through FIX (must not requeue)
        load(8'h20);
        bus.brreq = 1'b1; bus.brneg = 1'b0;
        tick();
        chk("fix_busy", {7'd0, bus.fixbusy}, 8'h01);
        chk("fix_preadj", adhout, 8'h20);
        tick();
        bus.brreq = 1'b0;
        chk("fix_plus", adhout, 8'h21);
        chk("fix_noqueue", {7'd0, bus.fixbusy}, 8'h00);

        // -1 across page 00 with inc&pclc ignored during FIX
        load(8'h00);
        bus.brreq = 1'b1; bus.brneg = 1'b1;
        tick();
        bus.brreq = 1'b0; bus.brneg = 1'b0;
        bus.inc = 1'b1; bus.pclc = 1'b1;
        tick();
        bus.inc = 1'b0; bus.pclc = 1'b0;
        chk("fix_minus_wrap", adhout, 8'hFF);
        chk("fix_done", {7'd0, bus.fixbusy}, 8'h00);

        // +1 across FF
        bus.brreq = 1'b1;
        tick();
        bus.brreq = 1'b0;
        tick();
        chk("fix_plus_wrap", adhout, 8'h00);

        // Carry on the request edge still increments
        load(8'h40);
        bus.brreq = 1'b1; bus.inc = 1'b1; bus.pclc = 1'b1;
        tick();
        bus.brreq = 1'b0; bus.inc = 1'b0; bus.pclc = 1'b0;
        chk("req_edge_inc", adhout, 8'h41);
        tick();
        chk("req_edge_fix", adhout, 8'h42);

        // 5. Abort: reset mid-fixup
        load(8'h30);
        bus.brreq = 1'b1;
        tick();
        bus.brreq = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_rst_pch", adhout, 8'h00);
        chk("abort_rst_busy", {7'd0, bus.fixbusy}, 8'h00);
        tick();
        chk("abort_rst_noadj", adhout, 8'h00);

        // Abort: ADH load wins over the adjust
        load(8'h50);
        bus.brreq = 1'b1;
        tick();
        bus.brreq = 1'b0;
        load(8'h7A);
        chk("abort_adh_pch", adhout, 8'h7A);
        chk("abort_adh_busy", {7'd0, bus.fixbusy}, 8'h00);
        tick();
        chk("abort_adh_hold", adhout, 8'h7A);

        // Abort: vector load wins over the adjust
        load(8'h60);
        bus.brreq = 1'b1; bus.brneg = 1'b1;
        tick();
        bus.brreq = 1'b0; bus.brneg = 1'b0;
        bus.setnmi = 1'b1;
        tick();
        bus.setnmi = 1'b0;
        chk("abort_vec_pch", adhout, 8'hFF);
        chk("abort_vec_busy", {7'd0, bus.fixbusy}, 8'h00);

        // Both drivers enabled together
        bus.dboa = 1'b1;
        #1 chk("both_db", dbout, 8'hFF);
        bus.adhoa = 1'b0;
        #1;
        checks++;
        assert (adhout === 8'hzz) else begin
            errors++;
            $error("FAIL adhout_float observed %h expected zz", adhout);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_high
`default_nettype wire

// File: doc/pc_high.md
Name: pc_high

Overview:
- Program-counter high byte (PCH) of the 6502 core; sits directly downstream of the PC low-byte stage and consumes its carry `pclc`.
- Holds PCH and increments it on a low-byte carry.
- Loads PCH from the ADH bus or from the vector page (FF) on reset/IRQ/NMI entry.
- Runs a one-cycle branch page-cross fixup FSM that adds +1/-1 to PCH while stalling the sequencer.
- Drives PCH onto the ADH bus and the data bus through tri-state enables.

Parameters:
- VECTOR_PAGE, 8'hFF, high byte loaded on setreset/setnmi/setirq.
- RESET_VAL, 8'h00, PCH value after rstn.

Ports:
- clk  input  1  core clock; all state changes on posedge
- rstn  input  1  reset, synchronous, active-low
- adhin  input  8  ADH bus value for load
- adhwa  input  1  load PCH from adhin
- inc  input  1  PC increment enable (same strobe fed to PC low)
- pclc  input  1  carry out of PC low byte
- setreset  input  1  load VECTOR_PAGE (reset vector)
- setnmi  input  1  load VECTOR_PAGE (NMI vector)
- setirq  input  1  load VECTOR_PAGE (IRQ/BRK vector)
- brreq  input  1  branch page cross detected by ALU; request PCH fixup
- brneg  input  1  fixup direction qualifier with brreq: 1 = -1, 0 = +1
- adhoa  input  1  drive PCH on adhout
- dboa  input  1  drive PCH on dbout
- adhout  output  8  PCH when adhoa, else 8'hzz
- dbout  output  8  PCH when dboa, else 8'hzz
- pchc  output  1  PC wrap: inc & pclc & (pch==8'hFF), combinational
- fixbusy  output  1  high for the fixup cycle; sequencer holds PC low/inc

Behaviour:
- Registers: pch[7:0], state {IDLE, FIX}, dirq (latched brneg).
- Reset (rstn==0 at posedge) puts the block in this state:
  - pch = RESET_VAL, state = IDLE, dirq = 0.
  - fixbusy = 0 and pchc = 0 once inc is low.
  - adhout/dbout follow the enables (pch = 00).
- Reset overrides every other input, including mid-fixup: FIX is abandoned and no adjust is applied.
- Priority per edge, highest first:
  - rstn
  - setreset
  - setnmi
  - setirq
  - adhwa
  - FIX adjust
  - inc & pclc increment
- Vector load: pch = VECTOR_PAGE. A vector load in FIX forces state to IDLE and cancels the adjust.
- adhwa: pch = adhin next edge; 1-cycle latency.
- Increment:
  - inc & pclc -> pch = pch + 1, mod 256. FF wraps to 00 and pchc is high that cycle.
  - inc without pclc -> no change.
  - pclc without inc is ignored.
- Fixup FSM:
  - IDLE with brreq=1 and no higher-priority load: state goes to FIX and dirq = brneg; pch is unchanged at this edge.
  - An inc & pclc on that same edge still increments.
  - FIX: fixbusy = 1 combinationally.
  - At the next edge pch = pch + 1 (dirq=0) or pch - 1 (dirq=1), mod 256 (00-1 = FF, FF+1 = 00), and state returns to IDLE.
  - inc & pclc during FIX is ignored; the sequencer must stall.
  - brreq during FIX is ignored; no back-to-back queueing.
  - adhwa during FIX: the load wins and state returns to IDLE.
- Outputs:
  - adhout/dbout are combinational from the current pch.
  - Both may be enabled at once.
  - During FIX they show the pre-adjust pch.

Optional Feature:
- Macro PC_HIGH_SAVE_EN.
- Defined, the block adds:
  - Output savedpch[7:0]: register, reset 00, captures pch (pre-load value) on any edge where setnmi or setirq is accepted.
  - Input restore: restore=1 (priority just below setirq) loads pch = savedpch.
- Not defined: no savedpch/restore ports, no extra register; behaviour is otherwise identical.

Decomposition:
- Shared package cpu6502_pkg:
  - VECTOR_PAGE
  - pc fixup state enum (PCF_IDLE, PCF_FIX)
  - bus-float constant 8'hzz
- One natural sub-module: pc_tribuf, an 8-bit tri-state driver (en, d -> q), instanced for adhout and dbout.
- Reusable by the PC low stage.

Test Plan:
1. Reset, load, drive: rstn=0 one edge -> pch=00, fixbusy=0. Then adhwa=1, adhin=8'h12 -> next edge adhout=8'h12 with adhoa=1, dbout=8'hzz with dboa=0.
2. Carry increment and wrap: pch=8'h34, inc=1, pclc=1 -> next edge 8'h35. Repeat with inc=1, pclc=0 -> stays 8'h35. Load FF, inc=pclc=1 -> pchc=1 that cycle, next edge pch=00.
3. Vector priority:
   - setreset=setirq=adhwa=1 with adhin=8'h55 -> pch=8'hFF.
   - setnmi and setirq together -> FF.
   - With PC_HIGH_SAVE_EN, setirq at pch=8'hC0 -> savedpch=8'hC0; restore -> pch=8'hC0.
4. Fixup both directions:
   - pch=8'h20, brreq=1, brneg=0 -> FIX, fixbusy=1 one cycle, pch=8'h21.
   - pch=8'h00, brneg=1 -> pch=8'hFF after FIX.
   - inc=pclc=1 during FIX -> ignored, result still 8'hFF.
5. Abort cases: brreq into FIX, then rstn=0 -> pch=00, IDLE. Separately, FIX with adhwa=1, adhin=8'h7A -> pch=8'h7A, no adjust, fixbusy low next cycle.
